// File: rtl/crc_serial_gen_if.sv
// Serial message/CRC handshake bundle for crc_serial_gen.
// Defining CRC_CHECK_EN adds the chk_mode / crc_err check-mode signals.
interface crc_serial_gen_if #(
  parameter int W = 3
);
  logic         start;
  logic         din;
  logic         din_valid;
  logic         din_last;
  logic         din_ready;
  logic         dout;
  logic         dout_valid;
  logic         dout_ready;
  logic [W-1:0] crc;
  logic         crc_valid;
  logic         busy;
`ifdef CRC_CHECK_EN
  logic         chk_mode;
  logic         crc_err;

  modport master (
    output start, din, din_valid, din_last, dout_ready, chk_mode,
    input  din_ready, dout, dout_valid, crc, crc_valid, busy, crc_err
  );

  modport slave (
    input  start, din, din_valid, din_last, dout_ready, chk_mode,
    output din_ready, dout, dout_valid, crc, crc_valid, busy, crc_err
  );
`else
  modport master (
    output start, din, din_valid, din_last, dout_ready,
    input  din_ready, dout, dout_valid, crc, crc_valid, busy
  );

  modport slave (
    input  start, din, din_valid, din_last, dout_ready,
    output din_ready, dout, dout_valid, crc, crc_valid, busy
  );
`endif
endinterface

// File: rtl/crc_serial_gen.sv
// Bit-serial CRC generator: shifts a message in MSB first, then shifts the W-bit CRC out.
// Defining CRC_CHECK_EN adds a check mode that flags a non-zero remainder on crc_err.
module crc_serial_gen #(
  parameter int           W    = 3,
  parameter logic [W-1:0] POLY = 3'b011,
  parameter logic [W-1:0] INIT = '0
) (
  input logic             clk,
  input logic             clr,
  crc_serial_gen_if.slave bus
);

  localparam int         CW   = (W > 2) ? $clog2(W) : 1;
  localparam logic [0:0] ACC  = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]    state_reg;
  logic [W-1:0]  crc_reg;
  logic [W-1:0]  sreg_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          chk_pend_reg;

  logic [W-1:0]  crc_base;
  logic [W-1:0]  crc_upd;
  logic          fb;
  logic          accept;
  logic          xfer;
  logic          chk_sel;
  logic          last_gen;
  logic          last_chk;

  // A finished check frame still shows its remainder for one cycle; a bit
  // accepted in that cycle already starts the next frame from INIT.
  assign crc_base = chk_pend_reg ? INIT : crc_reg;
  assign fb       = bus.din ^ crc_base[W-1];

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_crc_bit
      if (gi == 0) begin : g_lsb
        assign crc_upd[gi] = fb & POLY[gi];
      end else begin : g_upper
        assign crc_upd[gi] = crc_base[gi-1] ^ (fb & POLY[gi]);
      end
    end
  endgenerate

`ifdef CRC_CHECK_EN
  assign chk_sel = bus.chk_mode;
`else
  assign chk_sel = 1'b0;
`endif

  assign bus.din_ready  = (state_reg == ACC) && !bus.start;
  assign accept         = bus.din_valid && bus.din_ready;
  assign xfer           = (state_reg == EMIT) && bus.dout_ready;
  assign last_gen       = accept && bus.din_last && !chk_sel;
  assign last_chk       = accept && bus.din_last && chk_sel;

  assign bus.dout       = (state_reg == EMIT) && sreg_reg[W-1];
  assign bus.dout_valid = (state_reg == EMIT);
  assign bus.crc_valid  = (state_reg == EMIT) || chk_pend_reg;
  assign bus.crc        = crc_reg;
  assign bus.busy       = busy_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg    <= ACC;
      crc_reg      <= INIT;
      sreg_reg     <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      chk_pend_reg <= 1'b0;
    end else if (bus.start) begin
      // Abort wins over any same-cycle input bit or output transfer.
      state_reg    <= ACC;
      crc_reg      <= INIT;
      sreg_reg     <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      chk_pend_reg <= 1'b0;
    end else begin
      chk_pend_reg <= last_chk;
      case (state_reg)
        ACC: begin
          if (accept) begin
            crc_reg  <= crc_upd;
            busy_reg <= 1'b1;
            if (last_gen) begin
              sreg_reg  <= crc_upd;
              cnt_reg   <= CW'(W - 1);
              state_reg <= EMIT;
            end
          end else if (chk_pend_reg) begin
            crc_reg  <= INIT;
            busy_reg <= 1'b0;
          end
        end
        EMIT: begin
          if (xfer) begin
            sreg_reg <= {sreg_reg[W-2:0], 1'b0};
            if (cnt_reg == '0) begin
              state_reg <= ACC;
              crc_reg   <= INIT;
              busy_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
        default: state_reg <= ACC;
      endcase
    end
  end

`ifdef CRC_CHECK_EN
  logic crc_err_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      crc_err_reg <= 1'b0;
    end else if (bus.start) begin
      crc_err_reg <= 1'b0;
    end else begin
      crc_err_reg <= last_chk && (|crc_upd);
    end
  end

  assign bus.crc_err = crc_err_reg;
`endif

endmodule

// File: tb/tb_crc_serial_gen.sv
// Directed table-driven bench for crc_serial_gen (W=3, POLY=x^3+x+1, INIT=0).
module tb_crc_serial_gen;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;

  crc_serial_gen_if #(.W(3)) bus ();

  crc_serial_gen #(.W(3), .POLY(3'b011), .INIT(3'b000)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, d, v, l, dr;
    logic [2:0] e_crc;
    logic       e_dout, e_dv, e_rdy, e_busy, e_cv;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, d, v, l, dr, input logic [2:0] e_crc,
                              input logic e_dout, e_dv, e_rdy, e_busy, e_cv);
    vec_t x;
    x.st = st; x.d = d; x.v = v; x.l = l; x.dr = dr;
    x.e_crc = e_crc; x.e_dout = e_dout; x.e_dv = e_dv;
    x.e_rdy = e_rdy; x.e_busy = e_busy; x.e_cv = e_cv;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".crc"}, 32'(bus.crc), 32'h0);
    chk({tag, ".din_ready"}, 32'(bus.din_ready), 32'h1);
    chk({tag, ".dout"}, 32'(bus.dout), 32'h0);
    chk({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'h0);
    chk({tag, ".crc_valid"}, 32'(bus.crc_valid), 32'h0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'h0);
  endtask

  task automatic drive(input logic st, d, v, l, dr);
    bus.start = st; bus.din = d; bus.din_valid = v; bus.din_last = l; bus.dout_ready = dr;
  endtask

  // Four-bit frame 1,1,0,1 from an idle ACC state; remainders 011,101,001,001.
  function automatic void add_frame(input logic dr);
    add(0, 1, 1, 0, dr, 3'b000, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, dr, 3'b011, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0, dr, 3'b101, 0, 0, 1, 1, 0);
    add(0, 1, 1, 1, dr, 3'b001, 0, 0, 1, 1, 0);
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b1;
    drive(0, 0, 0, 0, 1);
`ifdef CRC_CHECK_EN
    bus.chk_mode = 1'b0;
`endif

    // Basic frame: dout 0,0,1 then back to idle.
    add_frame(1);
    add(0, 0, 0, 0, 1, 3'b001, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b001, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b001, 1, 1, 0, 1, 1);
    // Backpressure: 5 stalled cycles, then interleaved stalls.
    add_frame(0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 3'b001, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b001, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 3'b001, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b001, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 3'b001, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b001, 1, 1, 0, 1, 1);
    // Start after the first dout transfer, then start overriding an input bit.
    add_frame(1);
    add(0, 0, 0, 0, 1, 3'b001, 0, 1, 0, 1, 1);
    add(1, 0, 0, 0, 1, 3'b001, 0, 1, 0, 1, 1);
    add(1, 1, 1, 0, 1, 3'b000, 0, 0, 0, 0, 0);
    // Fresh frame after the abort, followed back-to-back by a single-bit frame.
    add_frame(1);
    add(0, 0, 0, 0, 1, 3'b001, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b001, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b001, 1, 1, 0, 1, 1);
    add(0, 1, 1, 1, 1, 3'b000, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 3'b011, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b011, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b011, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 3'b000, 0, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
`ifdef CRC_CHECK_EN
    chk("reset.crc_err", 32'(bus.crc_err), 32'h0);
`endif
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].d, vecs[i].v, vecs[i].l, vecs[i].dr);
      #1;
      chk($sformatf("v%0d.crc", i), 32'(bus.crc), 32'(vecs[i].e_crc));
      chk($sformatf("v%0d.dout", i), 32'(bus.dout), 32'(vecs[i].e_dout));
      chk($sformatf("v%0d.dout_valid", i), 32'(bus.dout_valid), 32'(vecs[i].e_dv));
      chk($sformatf("v%0d.din_ready", i), 32'(bus.din_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d.crc_valid", i), 32'(bus.crc_valid), 32'(vecs[i].e_cv));
      $display("vec %0d: st=%0b din=%0b v=%0b last=%0b dr=%0b -> crc=%03b dout=%0b dv=%0b rdy=%0b",
               i, vecs[i].st, vecs[i].d, vecs[i].v, vecs[i].l, vecs[i].dr,
               bus.crc, bus.dout, bus.dout_valid, bus.din_ready);
    end

    // clr mid-frame in ACC: two bits in, then asynchronous clear.
    @(negedge clk); drive(0, 1, 1, 0, 1);
    @(negedge clk); drive(0, 1, 1, 0, 1);
    @(negedge clk); drive(0, 0, 0, 0, 1);
    #1;
    chk("clr_acc.pre_crc", 32'(bus.crc), 32'h5);
    #1; clr = 1'b1; #1;
    chk_idle("clr_acc");
    $display("clr during ACC: crc=%03b busy=%0b", bus.crc, bus.busy);
    @(negedge clk); clr = 1'b0;

    // clr mid-EMIT: frame 1,1,0,1 then clear with the CRC half shifted out.
    @(negedge clk); drive(0, 1, 1, 0, 0);
    @(negedge clk); drive(0, 1, 1, 0, 0);
    @(negedge clk); drive(0, 0, 1, 0, 0);
    @(negedge clk); drive(0, 1, 1, 1, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1);
    #1;
    chk("clr_emit.pre_dv", 32'(bus.dout_valid), 32'h1);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    #1; clr = 1'b1; #1;
    chk_idle("clr_emit");
    $display("clr during EMIT: dout_valid=%0b crc=%03b", bus.dout_valid, bus.crc);
    @(negedge clk); clr = 1'b0; drive(0, 0, 0, 0, 1);
    #1;
    chk_idle("clr_release");

`ifdef CRC_CHECK_EN
    begin
      logic [6:0] good;
      logic [6:0] bad;
      good = 7'b1101001;
      bad  = 7'b1111001;
      bus.chk_mode = 1'b1;
      for (int f = 0; f < 2; f++) begin
        for (int i = 6; i >= 0; i--) begin
          @(negedge clk);
          drive(0, (f == 0) ? good[i] : bad[i], 1, (i == 0), 1);
        end
        @(negedge clk); drive(0, 0, 0, 0, 1);
        #1;
        chk($sformatf("chk%0d.crc_err", f), 32'(bus.crc_err), (f == 0) ? 32'h0 : 32'h1);
        chk($sformatf("chk%0d.crc", f), 32'(bus.crc), (f == 0) ? 32'h0 : 32'h1);
        chk($sformatf("chk%0d.crc_valid", f), 32'(bus.crc_valid), 32'h1);
        chk($sformatf("chk%0d.dout_valid", f), 32'(bus.dout_valid), 32'h0);
        $display("check frame %0d: crc_err=%0b crc=%03b", f, bus.crc_err, bus.crc);
        @(negedge clk);
        #1;
        chk($sformatf("chk%0d.err_clear", f), 32'(bus.crc_err), 32'h0);
        chk($sformatf("chk%0d.crc_reload", f), 32'(bus.crc), 32'h0);
        chk($sformatf("chk%0d.cv_clear", f), 32'(bus.crc_valid), 32'h0);
        chk($sformatf("chk%0d.dv_clear", f), 32'(bus.dout_valid), 32'h0);
      end
      bus.chk_mode = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
